// File: rtl/stopwatch_counter.sv
// Stopwatch timekeeping core: millisecond prescaler, H:MM:SS.mmm binary count with
// start/stop, clear and lap-freeze control, saturating at MAX_HOURS:59:59.999.
module stopwatch_counter #(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int MS_DIVIDER  = CLK_FREQ_HZ / 1000,
    parameter int MAX_HOURS   = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       lap,
    output logic [3:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic [9:0] milliseconds,
    output logic       running,
    output logic       lap_hold,
    output logic       overflow
);

    localparam int              PW         = (MS_DIVIDER > 2) ? $clog2(MS_DIVIDER) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(MS_DIVIDER - 1);
    localparam logic [3:0]      H_MAX      = 4'(MAX_HOURS);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUNNING = 2'd1,
        S_PAUSED  = 2'd2
    } state_t;

    state_t        r_state, w_state_next;
    logic [PW-1:0] r_presc, w_presc_next;
    logic [3:0]    r_hours, w_hours_next;
    logic [5:0]    r_min, w_min_next;
    logic [5:0]    r_sec, w_sec_next;
    logic [9:0]    r_ms, w_ms_next;
    logic          r_lap_hold, w_lap_hold_next;
    logic          r_overflow, w_overflow_next;
    logic [3:0]    r_disp_hours;
    logic [5:0]    r_disp_min;
    logic [5:0]    r_disp_sec;
    logic [9:0]    r_disp_ms;
    logic          w_tick;
    logic          w_at_max;
    logic          w_disp_load;

    assign w_tick   = (r_state == S_RUNNING) && (r_presc == PRESC_LAST);
    assign w_at_max = (r_hours == H_MAX) && (r_min == 6'd59) &&
                      (r_sec == 6'd59) && (r_ms == 10'd999);

    always_comb begin
        w_state_next    = r_state;
        w_presc_next    = r_presc;
        w_hours_next    = r_hours;
        w_min_next      = r_min;
        w_sec_next      = r_sec;
        w_ms_next       = r_ms;
        w_lap_hold_next = r_lap_hold;
        w_overflow_next = r_overflow;

        if (r_state == S_RUNNING) begin
            w_presc_next = w_tick ? '0 : r_presc + 1'b1;
        end

        if (w_tick) begin
            if (w_at_max) begin
                w_overflow_next = 1'b1;
                w_state_next    = S_PAUSED;
            end else if (r_ms != 10'd999) begin
                w_ms_next = r_ms + 10'd1;
            end else begin
                w_ms_next = '0;
                if (r_sec != 6'd59) begin
                    w_sec_next = r_sec + 6'd1;
                end else begin
                    w_sec_next = '0;
                    if (r_min != 6'd59) begin
                        w_min_next = r_min + 6'd1;
                    end else begin
                        w_min_next   = '0;
                        w_hours_next = r_hours + 4'd1;
                    end
                end
            end
        end

        // A pausing start_stop coincident with a tick still keeps the tick's increment.
        case (r_state)
            S_IDLE: begin
                if (start_stop) begin
                    w_state_next = S_RUNNING;
                    w_presc_next = '0;
                end
            end
            S_RUNNING: begin
                if (start_stop) w_state_next = S_PAUSED;
            end
            S_PAUSED: begin
                if (start_stop && !r_overflow) w_state_next = S_RUNNING;
            end
            default: w_state_next = S_IDLE;
        endcase

        if (lap && (r_state == S_RUNNING || r_state == S_PAUSED)) begin
            w_lap_hold_next = ~r_lap_hold;
        end

        if (clear) begin
            w_state_next    = S_IDLE;
            w_presc_next    = '0;
            w_hours_next    = '0;
            w_min_next      = '0;
            w_sec_next      = '0;
            w_ms_next       = '0;
            w_lap_hold_next = 1'b0;
            w_overflow_next = 1'b0;
        end
    end

    // Display follows the live next-value except while a lap freeze is held across the edge.
    assign w_disp_load = !(r_lap_hold && w_lap_hold_next);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_presc      <= '0;
            r_hours      <= '0;
            r_min        <= '0;
            r_sec        <= '0;
            r_ms         <= '0;
            r_lap_hold   <= 1'b0;
            r_overflow   <= 1'b0;
            r_disp_hours <= '0;
            r_disp_min   <= '0;
            r_disp_sec   <= '0;
            r_disp_ms    <= '0;
        end else begin
            r_state    <= w_state_next;
            r_presc    <= w_presc_next;
            r_hours    <= w_hours_next;
            r_min      <= w_min_next;
            r_sec      <= w_sec_next;
            r_ms       <= w_ms_next;
            r_lap_hold <= w_lap_hold_next;
            r_overflow <= w_overflow_next;
            if (w_disp_load) begin
                r_disp_hours <= w_hours_next;
                r_disp_min   <= w_min_next;
                r_disp_sec   <= w_sec_next;
                r_disp_ms    <= w_ms_next;
            end
        end
    end

    assign hours        = r_disp_hours;
    assign minutes      = r_disp_min;
    assign seconds      = r_disp_sec;
    assign milliseconds = r_disp_ms;
    assign running      = (r_state == S_RUNNING);
    assign lap_hold     = r_lap_hold;
    assign overflow     = r_overflow;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter with MS_DIVIDER=4: a vector table for basic
// control sequencing plus hand-written sequences for carries, saturation, lap and reset.
module tb_stopwatch_counter;

    logic       clk;
    logic       rst_n;
    logic       start_stop;
    logic       clear;
    logic       lap;
    logic [3:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic [9:0] milliseconds;
    logic       running;
    logic       lap_hold;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    stopwatch_counter #(
        .CLK_FREQ_HZ(4000),
        .MS_DIVIDER (4),
        .MAX_HOURS  (9)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_stop  (start_stop),
        .clear       (clear),
        .lap         (lap),
        .hours       (hours),
        .minutes     (minutes),
        .seconds     (seconds),
        .milliseconds(milliseconds),
        .running     (running),
        .lap_hold    (lap_hold),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       ss;
        logic       cl;
        logic       lp;
        logic [9:0] ms;
        logic       run;
        logic       lh;
        logic       ov;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(input logic ss, input logic cl, input logic lp,
                                input int ms, input logic run, input logic lh,
                                input logic ov);
        vec_t v;
        v.ss  = ss;
        v.cl  = cl;
        v.lp  = lp;
        v.ms  = 10'(ms);
        v.run = run;
        v.lh  = lh;
        v.ov  = ov;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input int h, input int m, input int s,
                           input int ms, input int run, input int lh, input int ov);
        chk({tag, ".hours"}, 32'(hours), 32'(h));
        chk({tag, ".minutes"}, 32'(minutes), 32'(m));
        chk({tag, ".seconds"}, 32'(seconds), 32'(s));
        chk({tag, ".ms"}, 32'(milliseconds), 32'(ms));
        chk({tag, ".running"}, 32'(running), 32'(run));
        chk({tag, ".lap_hold"}, 32'(lap_hold), 32'(lh));
        chk({tag, ".overflow"}, 32'(overflow), 32'(ov));
        $display("%-10s t=%0t  %0d:%02d:%02d.%03d run=%0b lap=%0b ovf=%0b",
                 tag, $time, hours, minutes, seconds, milliseconds,
                 running, lap_hold, overflow);
    endtask

    // Drive one cycle of pulses; returns 1 time unit after the active edge.
    task automatic step(input logic ss, input logic cl, input logic lp);
        start_stop = ss;
        clear      = cl;
        lap        = lp;
        @(posedge clk);
        #1;
        start_stop = 1'b0;
        clear      = 1'b0;
        lap        = 1'b0;
    endtask

    task automatic preload(input logic [3:0] h);
        force dut.r_hours = h;
        force dut.r_min   = 6'd59;
        force dut.r_sec   = 6'd59;
        force dut.r_ms    = 10'd999;
        step(1'b0, 1'b0, 1'b0);
        release dut.r_hours;
        release dut.r_min;
        release dut.r_sec;
        release dut.r_ms;
    endtask

    initial begin
        //            ss cl lp  ms run lh ov
        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(0, 0, 1, 0, 0, 0, 0);  // lap ignored in IDLE
        vecs[2]  = mk(1, 0, 0, 0, 1, 0, 0);  // start, prescaler 0
        vecs[3]  = mk(0, 0, 0, 0, 1, 0, 0);
        vecs[4]  = mk(0, 0, 0, 0, 1, 0, 0);
        vecs[5]  = mk(0, 0, 0, 0, 1, 0, 0);
        vecs[6]  = mk(0, 0, 0, 1, 1, 0, 0);  // 4th edge after start: first tick
        vecs[7]  = mk(1, 0, 0, 1, 0, 0, 0);  // pause, prescaler now 1
        vecs[8]  = mk(0, 0, 0, 1, 0, 0, 0);
        vecs[9]  = mk(0, 0, 1, 1, 0, 1, 0);  // lap while paused
        vecs[10] = mk(1, 0, 0, 1, 1, 1, 0);  // resume, prescaler kept at 1
        vecs[11] = mk(0, 0, 0, 1, 1, 1, 0);
        vecs[12] = mk(0, 0, 0, 1, 1, 1, 0);
        vecs[13] = mk(0, 0, 0, 1, 1, 1, 0);  // live ms=2, display frozen at 1
        vecs[14] = mk(0, 0, 1, 2, 1, 0, 0);  // unfreeze shows live value
        vecs[15] = mk(0, 0, 0, 2, 1, 0, 0);
        vecs[16] = mk(1, 1, 1, 0, 0, 0, 0);  // clear wins over start_stop and lap
        vecs[17] = mk(0, 0, 0, 0, 0, 0, 0);

        rst_n      = 1'b0;
        start_stop = 1'b0;
        clear      = 1'b0;
        lap        = 1'b0;
        #3;
        chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
        #9;
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            step(vecs[i].ss, vecs[i].cl, vecs[i].lp);
            chk_all($sformatf("vec%0d", i), 0, 0, 0, int'(vecs[i].ms),
                    int'(vecs[i].run), int'(vecs[i].lh), int'(vecs[i].ov));
        end

        // First tick latency and ms->seconds carry
        step(1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        chk_all("t1_e3", 0, 0, 0, 0, 1, 0, 0);
        step(1'b0, 1'b0, 1'b0);
        chk_all("t1_e4", 0, 0, 0, 1, 1, 0, 0);
        repeat (3995) step(1'b0, 1'b0, 1'b0);
        chk_all("t1_999", 0, 0, 0, 999, 1, 0, 0);
        step(1'b0, 1'b0, 1'b0);
        chk_all("t1_1s", 0, 0, 1, 0, 1, 0, 0);

        // Lap freeze while counting continues
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        repeat (48) step(1'b0, 1'b0, 1'b0);
        chk_all("t4_12ms", 0, 0, 0, 12, 1, 0, 0);
        step(1'b0, 1'b0, 1'b1);
        chk_all("t4_lapon", 0, 0, 0, 12, 1, 1, 0);
        for (int i = 0; i < 199; i++) begin
            step(1'b0, 1'b0, 1'b0);
            chk("t4_frozen", 32'(milliseconds), 32'd12);
        end
        step(1'b0, 1'b0, 1'b1);
        chk_all("t4_lapoff", 0, 0, 0, 62, 1, 0, 0);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        chk_all("t4_track", 0, 0, 0, 63, 1, 0, 0);

        // Pause at prescaler=2, resume needs only 2 edges to the next tick
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk_all("t5_pause", 0, 0, 0, 0, 0, 0, 0);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        chk_all("t5_held", 0, 0, 0, 0, 0, 0, 0);
        step(1'b1, 1'b0, 1'b0);
        chk_all("t5_resume", 0, 0, 0, 0, 1, 0, 0);
        step(1'b0, 1'b0, 1'b0);
        chk_all("t5_r1", 0, 0, 0, 0, 1, 0, 0);
        step(1'b0, 1'b0, 1'b0);
        chk_all("t5_r2", 0, 0, 0, 1, 1, 0, 0);
        step(1'b1, 1'b1, 1'b0);
        chk_all("t5_clrss", 0, 0, 0, 0, 0, 0, 0);
        step(1'b0, 1'b0, 1'b0);
        chk_all("t5_idle", 0, 0, 0, 0, 0, 0, 0);

        // Minute->hour carry from 0:59:59.999
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        preload(4'd0);
        chk_all("t2_load", 0, 59, 59, 999, 0, 0, 0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk_all("t2_pre", 0, 59, 59, 999, 1, 0, 0);
        step(1'b0, 1'b0, 1'b0);
        chk_all("t2_carry", 1, 0, 0, 0, 1, 0, 0);

        // Saturation at 9:59:59.999
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        preload(4'd9);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk_all("t3_pre", 9, 59, 59, 999, 1, 0, 0);
        step(1'b0, 1'b0, 1'b0);
        chk_all("t3_sat", 9, 59, 59, 999, 0, 0, 1);
        step(1'b1, 1'b0, 1'b0);
        chk_all("t3_ssign", 9, 59, 59, 999, 0, 0, 1);
        repeat (5) step(1'b0, 1'b0, 1'b0);
        chk_all("t3_hold", 9, 59, 59, 999, 0, 0, 1);
        step(1'b0, 1'b1, 1'b0);
        chk_all("t3_clear", 0, 0, 0, 0, 0, 0, 0);
        step(1'b1, 1'b0, 1'b0);
        chk_all("t3_restart", 0, 0, 0, 0, 1, 0, 0);

        // Asynchronous reset between edges
        repeat (10) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        chk_all("t6_before", 0, 0, 0, 2, 1, 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("t6_async", 0, 0, 0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_all("t6_rel", 0, 0, 0, 0, 0, 0, 0);
        repeat (6) step(1'b0, 1'b0, 1'b0);
        chk_all("t6_idle", 0, 0, 0, 0, 0, 0, 0);
        step(1'b1, 1'b0, 1'b0);
        chk_all("t6_start", 0, 0, 0, 0, 1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
